// File: rtl/traceback_reader_if.sv
// traceback_reader_if: start, RAM read and step stream signals
// for the Needleman-Wunsch traceback reader.
interface traceback_reader_if #(
  parameter int W = 8
);
  logic         start;
  logic         rd_en;
  logic [W-1:0] i;
  logic [W-1:0] j;
  logic [1:0]   dir;
  logic         step_valid;
  logic [1:0]   step_dir;
  logic         step_ready;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    input  start, dir, step_ready,
    output rd_en, i, j, step_valid, step_dir,
    output busy, done, err
  );

  modport slave (
    output start, dir, step_ready,
    input  rd_en, i, j, step_valid, step_dir,
    input  busy, done, err
  );
endinterface

// File: rtl/traceback_reader.sv
// traceback_reader: walks the direction RAM from (N-1,N-1)
// to (0,0) and streams one alignment step per move.
module traceback_reader #(
  parameter int N       = 128,
  parameter int RAM_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  traceback_reader_if.master bus
);
  localparam int W  = $clog2(N) + 1;
  localparam int CW = $clog2(RAM_LAT + 1);

  localparam logic [1:0] DIAG = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] LEFT = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, EMIT, DONE
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] i_q, i_n, j_q, j_n;
  logic [W-1:0] i_nx, j_nx;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]   dir_q, dir_n;
  logic         err_q, err_n;
  logic         bad;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i_q   <= '0;
      j_q   <= '0;
      cnt_q <= '0;
      dir_q <= DIAG;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      i_q   <= i_n;
      j_q   <= j_n;
      cnt_q <= cnt_n;
      dir_q <= dir_n;
      err_q <= err_n;
    end
  end

  // next-state, index update and direction checks
  always_comb begin
    state_n = state;
    i_n     = i_q;
    j_n     = j_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    err_n   = err_q;
    i_nx    = (dir_q != LEFT) ? i_q - W'(1) : i_q;
    j_nx    = (dir_q != UP)   ? j_q - W'(1) : j_q;
    bad     = (bus.dir == ILL)
            | (!bus.dir[1] && i_q == '0)
            | (!bus.dir[0] && j_q == '0);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          i_n     = W'(N - 1);
          j_n     = W'(N - 1);
          err_n   = 1'b0;
          state_n = READ;
        end
      end
      READ: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(RAM_LAT - 1)) begin
          if (bad) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            dir_n   = bus.dir;
            state_n = EMIT;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      EMIT: begin
        if (bus.step_ready) begin
          i_n = i_nx;
          j_n = j_nx;
          if (i_nx == '0 && j_nx == '0) begin
            state_n = DONE;
          end else if (i_nx == '0) begin
            dir_n = LEFT;
          end else if (j_nx == '0) begin
            dir_n = UP;
          end else begin
            state_n = READ;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.rd_en      = (state == READ);
  assign bus.step_valid = (state == EMIT);
  assign bus.step_dir   = (state == EMIT) ? dir_q : DIAG;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
  assign bus.i          = i_q;
  assign bus.j          = j_q;
endmodule

// File: tb/tb_traceback_reader.sv
// tb_traceback_reader: directed checks of the traceback reader
// with N=4 at RAM_LAT=1 (bus_a) and RAM_LAT=3 (bus_b).
module tb_traceback_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  logic [5:0] rd_q[$];
  logic [1:0] st_q[$];
  logic       done_seen;
  logic [5:0] done_ij;

  traceback_reader_if #(.W(3)) bus_a ();
  traceback_reader_if #(.W(3)) bus_b ();

  traceback_reader #(.N(4), .RAM_LAT(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  traceback_reader #(.N(4), .RAM_LAT(3)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic run_a(input int max_cyc);
    rd_q.delete();
    st_q.delete();
    done_seen = 1'b0;
    done_ij   = '1;
    for (int c = 0; c < max_cyc; c++) begin
      if (!bus_a.busy) break;
      if (bus_a.rd_en) rd_q.push_back({bus_a.i, bus_a.j});
      if (bus_a.step_valid && bus_a.step_ready)
        st_q.push_back(bus_a.step_dir);
      if (bus_a.done) begin
        done_seen = 1'b1;
        done_ij   = {bus_a.i, bus_a.j};
      end
      tick();
    end
    vecs++;
    if (bus_a.busy !== 1'b0) begin
      errs++;
      $display("FAIL run_timeout: busy=%b required 0", bus_a.busy);
    end
  endtask

  task automatic test_reset();
    logic [12:0] o;
    tick();
    tick();
    o = {bus_a.rd_en, bus_a.step_valid, bus_a.step_dir,
         bus_a.busy, bus_a.done, bus_a.err, bus_a.i, bus_a.j};
    vecs++;
    if (o !== 13'd0) begin
      errs++;
      $display("FAIL reset_held: outs=%b required 0", o);
    end
    rst = 1'b0;
    tick();
    o = {bus_a.rd_en, bus_a.step_valid, bus_a.step_dir,
         bus_a.busy, bus_a.done, bus_a.err, bus_a.i, bus_a.j};
    vecs++;
    if (o !== 13'd0) begin
      errs++;
      $display("FAIL reset_idle: outs=%b required 0", o);
    end
  endtask

  task automatic test_diag();
    logic [5:0] exp_rd [3] = '{6'o33, 6'o22, 6'o11};
    bus_a.dir = 2'b00;
    bus_a.step_ready = 1'b1;
    start_a();
    run_a(60);
    vecs++;
    if (rd_q.size() != 3) begin
      errs++;
      $display("FAIL diag_reads: count=%0d required 3", rd_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (rd_q[k] !== exp_rd[k]) begin
          errs++;
          $display("FAIL diag_rd%0d: ij=%o required %o",
                   k, rd_q[k], exp_rd[k]);
        end
      end
    end
    vecs++;
    if (st_q.size() != 3 || st_q[0] !== 2'b00 ||
        st_q[1] !== 2'b00 || st_q[2] !== 2'b00) begin
      errs++;
      $display("FAIL diag_steps: count=%0d required 3 diag",
               st_q.size());
    end
    vecs++;
    if ({done_seen, done_ij, bus_a.err} !== {1'b1, 6'o00, 1'b0}) begin
      errs++;
      $display("FAIL diag_done: done=%b ij=%o err=%b required 1 00 0",
               done_seen, done_ij, bus_a.err);
    end
  endtask

  task automatic test_left_forced();
    logic [5:0] exp_rd [3] = '{6'o33, 6'o32, 6'o31};
    logic [1:0] exp_st [6] = '{2'b10, 2'b10, 2'b10,
                               2'b01, 2'b01, 2'b01};
    bus_a.dir = 2'b10;
    bus_a.step_ready = 1'b1;
    start_a();
    run_a(60);
    vecs++;
    if (rd_q.size() != 3) begin
      errs++;
      $display("FAIL left_reads: count=%0d required 3", rd_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (rd_q[k] !== exp_rd[k]) begin
          errs++;
          $display("FAIL left_rd%0d: ij=%o required %o",
                   k, rd_q[k], exp_rd[k]);
        end
      end
    end
    vecs++;
    if (st_q.size() != 6) begin
      errs++;
      $display("FAIL left_steps: count=%0d required 6", st_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vecs++;
        if (st_q[k] !== exp_st[k]) begin
          errs++;
          $display("FAIL left_st%0d: dir=%b required %b",
                   k, st_q[k], exp_st[k]);
        end
      end
    end
    vecs++;
    if (done_seen !== 1'b1) begin
      errs++;
      $display("FAIL left_done: done=%b required 1", done_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] o;
    bus_a.dir = 2'b00;
    bus_a.step_ready = 1'b0;
    start_a();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      o = {bus_a.step_valid, bus_a.step_dir,
           bus_a.i, bus_a.j, bus_a.rd_en};
      vecs++;
      if (o !== {1'b1, 2'b00, 3'd3, 3'd3, 1'b0}) begin
        errs++;
        $display("FAIL bp_hold%0d: v,dir,i,j,rd=%b required 1000110110",
                 k, o);
      end
      tick();
    end
    bus_a.step_ready = 1'b1;
    tick();
    vecs++;
    if ({bus_a.rd_en, bus_a.i, bus_a.j} !== {1'b1, 3'd2, 3'd2}) begin
      errs++;
      $display("FAIL bp_release: rd=%b i=%0d j=%0d required 1 2 2",
               bus_a.rd_en, bus_a.i, bus_a.j);
    end
    run_a(60);
    vecs++;
    if (st_q.size() != 2 || done_seen !== 1'b1) begin
      errs++;
      $display("FAIL bp_finish: steps=%0d done=%b required 2 1",
               st_q.size(), done_seen);
    end
  endtask

  task automatic test_illegal();
    logic seen;
    bus_a.dir = 2'b11;
    bus_a.step_ready = 1'b1;
    start_a();
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen = seen | bus_a.step_valid | bus_a.done;
      tick();
    end
    vecs++;
    if ({bus_a.err, bus_a.busy, seen} !== 3'b100) begin
      errs++;
      $display("FAIL ill_err: err=%b busy=%b step_or_done=%b required 1 0 0",
               bus_a.err, bus_a.busy, seen);
    end
    bus_a.dir = 2'b00;
    start_a();
    vecs++;
    if ({bus_a.err, bus_a.rd_en, bus_a.i, bus_a.j} !==
        {1'b0, 1'b1, 3'd3, 3'd3}) begin
      errs++;
      $display("FAIL ill_restart: err=%b rd=%b i=%0d j=%0d required 0 1 3 3",
               bus_a.err, bus_a.rd_en, bus_a.i, bus_a.j);
    end
    run_a(60);
    vecs++;
    if (st_q.size() != 3 || done_seen !== 1'b1) begin
      errs++;
      $display("FAIL ill_finish: steps=%0d done=%b required 3 1",
               st_q.size(), done_seen);
    end
  endtask

  task automatic test_mid_op();
    logic [12:0] o;
    bus_a.dir = 2'b00;
    bus_a.step_ready = 1'b1;
    start_a();
    tick();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    vecs++;
    if ({bus_a.step_valid, bus_a.i, bus_a.j, bus_a.err} !==
        {1'b1, 3'd3, 3'd3, 1'b0}) begin
      errs++;
      $display("FAIL mid_start: v=%b i=%0d j=%0d err=%b required 1 3 3 0",
               bus_a.step_valid, bus_a.i, bus_a.j, bus_a.err);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = {bus_a.rd_en, bus_a.step_valid, bus_a.step_dir,
         bus_a.busy, bus_a.done, bus_a.err, bus_a.i, bus_a.j};
    vecs++;
    if (o !== 13'd0) begin
      errs++;
      $display("FAIL mid_rst: outs=%b required 0", o);
    end
    start_a();
    vecs++;
    if ({bus_a.rd_en, bus_a.i, bus_a.j} !== {1'b1, 3'd3, 3'd3}) begin
      errs++;
      $display("FAIL mid_restart: rd=%b i=%0d j=%0d required 1 3 3",
               bus_a.rd_en, bus_a.i, bus_a.j);
    end
    run_a(60);
    vecs++;
    if (st_q.size() != 3 || done_seen !== 1'b1) begin
      errs++;
      $display("FAIL mid_finish: steps=%0d done=%b required 3 1",
               st_q.size(), done_seen);
    end
  endtask

  task automatic test_latency();
    int rd_c[$];
    int sv_c[$];
    int done_c;
    bus_b.dir = 2'b00;
    bus_b.step_ready = 1'b1;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    done_c = -1;
    for (int c = 0; c < 60 && bus_b.busy; c++) begin
      if (bus_b.rd_en) rd_c.push_back(c);
      if (bus_b.step_valid) sv_c.push_back(c);
      if (bus_b.done) done_c = c;
      tick();
    end
    vecs++;
    if (rd_c.size() != 3 || sv_c.size() != 3) begin
      errs++;
      $display("FAIL lat_counts: reads=%0d steps=%0d required 3 3",
               rd_c.size(), sv_c.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (rd_c[k] !== 5 * k) begin
          errs++;
          $display("FAIL lat_rd%0d: cycle=%0d required %0d",
                   k, rd_c[k], 5 * k);
        end
        vecs++;
        if (sv_c[k] - rd_c[k] !== 4) begin
          errs++;
          $display("FAIL lat_gap%0d: rd_to_valid=%0d required 4",
                   k, sv_c[k] - rd_c[k]);
        end
      end
    end
    vecs++;
    if (done_c !== 15) begin
      errs++;
      $display("FAIL lat_done: cycle=%0d required 15", done_c);
    end
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_a.dir = 2'b00;
    bus_a.step_ready = 1'b0;
    bus_b.start = 1'b0;
    bus_b.dir = 2'b00;
    bus_b.step_ready = 1'b0;
    test_reset();
    test_diag();
    test_left_forced();
    test_backpressure();
    test_illegal();
    test_mid_op();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
